// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared datapath widths, the hard-wired zero register index and the register index type
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = 5'd0;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy bits: set on reserve, clear on writeback, reserve wins a same-cycle tie
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_set_en,
  input  logic [ADDR_W-1:0]    i_set_idx,
  input  logic                 i_clr_en,
  input  logic [ADDR_W-1:0]    i_clr_idx,
  output logic [2**ADDR_W-1:0] o_busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_next;

  // A reserve in the same cycle as a writeback belongs to a younger producer, so it must survive the clear.
  always_comb begin
    w_busy_next = r_busy;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_set_en && (i_set_idx == ADDR_W'(i))) begin
        w_busy_next[i] = 1'b1;
      end else if (i_clr_en && (i_clr_idx == ADDR_W'(i))) begin
        w_busy_next[i] = 1'b0;
      end
    end
    if (ZERO_REG != 0) begin
      w_busy_next[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign o_busy_vec = r_busy;

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - 2R/1W register file with optional write bypass and a RAW-hazard busy scoreboard
module reg_file_sb
  import mips_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RegWrite,
  input  logic [ADDR_W-1:0]    wr_reg,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [ADDR_W-1:0]    rd_reg1,
  input  logic [ADDR_W-1:0]    rd_reg2,
  output logic [DATA_W-1:0]    rd_data1,
  output logic [DATA_W-1:0]    rd_data2,
  input  logic                 reserve_en,
  input  logic [ADDR_W-1:0]    reserve_reg,
  output logic                 busy1,
  output logic                 busy2,
  output logic [2**ADDR_W-1:0] busy_vec
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              w_wr_ok;
  logic [ADDR_W-1:0] w_idx  [2];
  logic [DATA_W-1:0] w_rd   [2];
  logic              w_busy [2];

  assign w_wr_ok = RegWrite && !((ZERO_REG != 0) && (wr_reg == ZERO_IDX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[wr_reg] <= wr_data;
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (reserve_en),
    .i_set_idx  (reserve_reg),
    .i_clr_en   (RegWrite),
    .i_clr_idx  (wr_reg),
    .o_busy_vec (busy_vec)
  );

  assign w_idx[0] = rd_reg1;
  assign w_idx[1] = rd_reg2;

  // Outputs are forced low during reset so a bypassed write cannot leak through while rst is held.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd[p]   = r_regs[w_idx[p]];
      w_busy[p] = busy_vec[w_idx[p]];
      if ((ZERO_REG != 0) && (w_idx[p] == ZERO_IDX)) begin
        w_rd[p] = '0;
      end else if ((BYPASS != 0) && w_wr_ok && (wr_reg == w_idx[p])) begin
        w_rd[p] = wr_data;
      end
      // The forwarded value resolves the hazard unless a new writer is reserved in the same cycle.
      if ((BYPASS != 0) && RegWrite && (wr_reg == w_idx[p]) &&
          !(reserve_en && (reserve_reg == w_idx[p]))) begin
        w_busy[p] = 1'b0;
      end
      if (rst) begin
        w_rd[p]   = '0;
        w_busy[p] = 1'b0;
      end
    end
  end

  assign rd_data1 = w_rd[0];
  assign rd_data2 = w_rd[1];
  assign busy1    = w_busy[0];
  assign busy2    = w_busy[1];

endmodule
